// File: rtl/myproject_dense_pkg.sv
// -----------------------------------------------------------------------------
// myproject_dense_pkg
// Shared types and helpers for the dense-layer pipeline stages.
//   - default widths for products, biases and results
//   - accum_state_t : accumulator FSM states
//   - sat_or_wrap() : narrows a wide signed value to out_w bits
// Build option:
//   MYPROJECT_ACC_SATURATE_EN  defined   -> sat_or_wrap clamps to the signed out_w range
//                              undefined -> sat_or_wrap keeps the low out_w bits (wrap)
// -----------------------------------------------------------------------------
package myproject_dense_pkg;

    localparam int PROD_W_DEF = 15;
    localparam int BIAS_W_DEF = 8;
    localparam int OUT_W_DEF  = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } accum_state_t;

    // Result is returned sign-extended to 64 bits; callers keep the low out_w bits.
    function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] sum,
                                                       input int                 out_w);
`ifdef MYPROJECT_ACC_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
`else
        // Push the kept field to the top, then shift back arithmetically to re-sign it.
        return (sum <<< (64 - out_w)) >>> (64 - out_w);
`endif
    endfunction

endpackage

// File: rtl/myproject_dense_accum_if.sv
// -----------------------------------------------------------------------------
// myproject_dense_accum_if
// Product-side and result-side handshake bundle of the dense accumulator.
//   prod_valid/prod_ready/prod_data/bias : product beats from the multipliers
//   out_valid/out_ready/out_data         : one result per neuron to the activation stage
//   busy                                 : group partially accumulated or result held
// Modports: slave (the accumulator), master (the surrounding logic / bench).
// -----------------------------------------------------------------------------
interface myproject_dense_accum_if #(
    parameter int PROD_W = 15,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 16
);
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [PROD_W-1:0] prod_data;
    logic signed [BIAS_W-1:0] bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;

    modport master (
        output prod_valid, prod_data, bias, out_ready,
        input  prod_ready, out_valid, out_data, busy
    );

    modport slave (
        input  prod_valid, prod_data, bias, out_ready,
        output prod_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/myproject_acc_fmt.sv
// -----------------------------------------------------------------------------
// myproject_acc_fmt
// Combinational rescale of the final neuron sum: arithmetic right shift by SHIFT
// (rounds toward minus infinity), then narrowing to OUT_W bits.
// Ports:
//   sum_i : ACC_W signed final sum
//   res_o : OUT_W signed formatted result
// Build option MYPROJECT_ACC_SATURATE_EN selects clamp (defined) or wrap (undefined)
// inside sat_or_wrap().
// -----------------------------------------------------------------------------
module myproject_acc_fmt
    import myproject_dense_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SHIFT = 0,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic signed [OUT_W-1:0] res_o
);

    logic signed [63:0] sum_ext;
    logic signed [63:0] shifted;

    always_comb begin
        sum_ext = {{(64-ACC_W){sum_i[ACC_W-1]}}, sum_i};
        shifted = sum_ext >>> SHIFT;
        res_o   = OUT_W'(sat_or_wrap(shifted, OUT_W));
    end

endmodule

// File: rtl/myproject_dense_accum.sv
// -----------------------------------------------------------------------------
// myproject_dense_accum
// Accumulates N_IN signed products per output neuron, adds the neuron bias
// (sampled with the group's first beat), rescales and emits one result.
// Ports:
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : myproject_dense_accum_if.slave (product and result handshakes, busy)
// Build option MYPROJECT_ACC_SATURATE_EN: clamp instead of wrap on the result.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | collecting product beats, prod_ready=1
// HOLD  | result registered, out_valid=1; beats accepted only if out_ready
// -----------------------------------------------------------------------------
module myproject_dense_accum
    import myproject_dense_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int N_IN   = 16,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int ACC_W  = PROD_W + $clog2(N_IN) + 1,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = OUT_W_DEF
) (
    input logic                   ap_clk,
    input logic                   ap_rst,
    myproject_dense_accum_if.slave bus
);

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    accum_state_t             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;

    logic                     prod_ready_w;
    logic                     beat_ok;
    logic                     last_beat;
    logic signed [BIAS_W-1:0] bias_sel;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  sum_fin;
    logic signed [OUT_W-1:0]  fmt_res;

    assign prod_ready_w   = (state_q == ACCUM) || bus.out_ready;
    assign bus.prod_ready = prod_ready_w;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = (cnt_q != '0) || out_valid_q;

    always_comb begin
        beat_ok   = bus.prod_valid && prod_ready_w;
        last_beat = (cnt_q == CNT_W'(N_IN - 1));
        // A single-beat group has no earlier cycle in which to register the bias.
        bias_sel  = (N_IN == 1) ? bus.bias : bias_q;
        prod_ext  = {{(ACC_W-PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};
        bias_ext  = {{(ACC_W-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel};
        // First beat restarts the sum, so no clear cycle is needed between groups.
        acc_base  = (cnt_q == '0) ? '0 : acc_q;
        sum_fin   = acc_base + prod_ext + bias_ext;
    end

    myproject_acc_fmt #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_fmt (
        .sum_i (sum_fin),
        .res_o (fmt_res)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if ((state_q == HOLD) && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
        end

        // Evaluated after the HOLD release so a final beat in the same cycle
        // re-enters HOLD with the new result.
        if (beat_ok) begin
            if (last_beat) begin
                out_data_d  = fmt_res;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = HOLD;
            end else begin
                acc_d = acc_base + prod_ext;
                if (cnt_q == '0) begin
                    bias_d = bus.bias;
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_myproject_dense_accum.sv
// -----------------------------------------------------------------------------
// tb_myproject_dense_accum
// Three accumulator instances (N_IN=4/SHIFT=0, N_IN=16/SHIFT=0, N_IN=1/SHIFT=2)
// checked against a per-instance group/queue reference model, with directed
// cases followed by randomized traffic and random output back-pressure.
// Build option MYPROJECT_ACC_SATURATE_EN selects the clamp expectations.
// -----------------------------------------------------------------------------
module tb_myproject_dense_accum;

    localparam int ND = 3;

    function automatic int nin_of(input int g);
        case (g)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic int sh_of(input int g);
        return (g == 2) ? 2 : 0;
    endfunction

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    logic              pv   [ND];
    logic signed [14:0] pd  [ND];
    logic signed [7:0]  bs  [ND];
    logic              ordy [ND];
    wire               prdy [ND];
    wire               ov   [ND];
    wire signed [15:0] od   [ND];
    wire               bsy  [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        myproject_dense_accum_if #(.PROD_W(15), .BIAS_W(8), .OUT_W(16)) bus ();
        assign bus.prod_valid = pv[g];
        assign bus.prod_data  = pd[g];
        assign bus.bias       = bs[g];
        assign bus.out_ready  = ordy[g];
        assign prdy[g]        = bus.prod_ready;
        assign ov[g]          = bus.out_valid;
        assign od[g]          = bus.out_data;
        assign bsy[g]         = bus.busy;

        myproject_dense_accum #(
            .PROD_W (15),
            .N_IN   (nin_of(g)),
            .BIAS_W (8),
            .SHIFT  (sh_of(g)),
            .OUT_W  (16)
        ) dut (
            .ap_clk (ap_clk),
            .ap_rst (ap_rst),
            .bus    (bus)
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: floor(sum / 2^sh), then clamp or wrap to 16 bits.
    function automatic longint ref_fmt(input longint s, input int sh);
        longint d;
        longint v;
        d = longint'(1) << sh;
        if (s >= 0) v = s / d;
        else        v = -((-s + d - 1) / d);
`ifdef MYPROJECT_ACC_SATURATE_EN
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`else
        v = v % 65536;
        if (v < 0)     v += 65536;
        if (v > 32767) v -= 65536;
`endif
        return v;
    endfunction

    longint m_sum   [ND];
    longint m_bias  [ND];
    int     m_cnt   [ND];
    longint exp_q   [ND][$];
    int     res_cnt [ND];
    longint last_out[ND];
    bit     ordy_rand[ND];

    // Monitor / scoreboard: at each falling edge compare outputs with the model,
    // then apply the transfers that the next rising edge will perform.
    initial begin
        bit held;
        int nn;
        for (int d = 0; d < ND; d++) begin
            m_sum[d] = 0; m_bias[d] = 0; m_cnt[d] = 0; res_cnt[d] = 0; last_out[d] = 0;
        end
        forever begin
            @(negedge ap_clk);
            for (int d = 0; d < ND; d++) begin
                nn   = nin_of(d);
                held = (exp_q[d].size() != 0);
                chk($sformatf("out_valid[%0d]", d), ov[d], held);
                chk($sformatf("prod_ready[%0d]", d), prdy[d], !held || ordy[d]);
                chk($sformatf("busy[%0d]", d), bsy[d], (m_cnt[d] != 0) || held);
                if (held) chk($sformatf("out_data[%0d]", d), od[d], exp_q[d][0]);
                if (ap_rst) begin
                    m_cnt[d] = 0;
                    m_sum[d] = 0;
                    exp_q[d].delete();
                end else begin
                    if (ov[d] && ordy[d] && held) begin
                        last_out[d] = od[d];
                        res_cnt[d]++;
                        void'(exp_q[d].pop_front());
                    end
                    if (pv[d] && prdy[d]) begin
                        if (m_cnt[d] == 0) begin
                            m_sum[d]  = 0;
                            m_bias[d] = longint'(bs[d]);
                        end
                        m_sum[d] += longint'(pd[d]);
                        m_cnt[d]++;
                        if (m_cnt[d] == nn) begin
                            exp_q[d].push_back(ref_fmt(m_sum[d] + m_bias[d], sh_of(d)));
                            m_cnt[d] = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            for (int d = 0; d < ND; d++)
                if (ordy_rand[d]) ordy[d] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; cyc = cycles it was presented.
    task automatic beat(input int d, input int data, input int b, output int cyc);
        bit done;
        done   = 1'b0;
        cyc    = 0;
        pv[d]  = 1'b1;
        pd[d]  = 15'(data);
        bs[d]  = 8'(b);
        while (!done) begin
            @(negedge ap_clk);
            done = prdy[d];
            step();
            cyc++;
            if (!done && cyc >= 200) begin
                chk($sformatf("beat_timeout[%0d]", d), 0, 1);
                done = 1'b1;
            end
        end
        pv[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int w;
        w = 0;
        ordy[d] = 1'b1;
        while (exp_q[d].size() != 0 && w < 100) begin
            step();
            w++;
        end
        chk($sformatf("drain[%0d]", d), exp_q[d].size(), 0);
    endtask

    initial begin
        int c;
        int r0;
        for (int d = 0; d < ND; d++) begin
            pv[d] = 1'b0; pd[d] = '0; bs[d] = '0; ordy[d] = 1'b1; ordy_rand[d] = 1'b0;
        end
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        for (int d = 0; d < ND; d++) begin
            chk("rst_out_data", od[d], 0);
            chk("rst_out_valid", ov[d], 0);
            chk("rst_busy", bsy[d], 0);
            chk("rst_prod_ready", prdy[d], 1);
        end

        // Basic group, bias only taken from the first beat.
        beat(0, 100, 5, c);
        beat(0, 200, 0, c);
        beat(0, -50, 0, c);
        beat(0, 10, 0, c);
        chk("t1_valid", ov[0], 1);
        chk("t1_data", od[0], 265);
        step();
        chk("t1_released", ov[0], 0);

        // Back-pressure on the result.
        ordy[0] = 1'b0;
        beat(0, 1, -3, c);
        beat(0, 2, 0, c);
        beat(0, 3, 0, c);
        beat(0, 4, 0, c);
        for (int i = 0; i < 3; i++) begin
            chk("t2_valid", ov[0], 1);
            chk("t2_data", od[0], 7);
            chk("t2_ready", prdy[0], 0);
            step();
        end
        ordy[0] = 1'b1;
        beat(0, 9, 0, c);
        chk("t2_resume_cycles", c, 1);
        chk("t2_valid_drop", ov[0], 0);
        chk("t2_busy", bsy[0], 1);
        beat(0, 9, 0, c);
        beat(0, 9, 0, c);
        beat(0, 9, 0, c);
        repeat (2) step();

        // Back-to-back groups with no bubble.
        r0 = res_cnt[0];
        for (int i = 0; i < 12; i++) begin
            beat(0, i * 7 - 20, i, c);
            chk("t3_ready_cycles", c, 1);
        end
        repeat (2) step();
        chk("t3_results", res_cnt[0] - r0, 3);

        // Overflow past 16 bits.
        for (int i = 0; i < 16; i++) beat(1, 16065, 0, c);
`ifdef MYPROJECT_ACC_SATURATE_EN
        chk("t4_pos", od[1], 32767);
`else
        chk("t4_pos", od[1], -5104);
`endif
        step();
        for (int i = 0; i < 16; i++) beat(1, -16320, 0, c);
`ifdef MYPROJECT_ACC_SATURATE_EN
        chk("t4_neg", od[1], -32768);
`else
        chk("t4_neg", od[1], 1024);
`endif
        repeat (2) step();

        // Reset mid-group discards the partial sum.
        r0 = res_cnt[0];
        beat(0, 5, 9, c);
        beat(0, 6, 0, c);
        chk("t5_busy_before", bsy[0], 1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        chk("t5_busy_after", bsy[0], 0);
        for (int i = 0; i < 4; i++) beat(0, 1, 0, c);
        chk("t5_data", od[0], 4);
        repeat (2) step();
        chk("t5_results", res_cnt[0] - r0, 1);

        // Single-beat groups with arithmetic shift.
        beat(2, -7, 0, c);
        chk("t6_floor", od[2], -2);
        beat(2, 5, 3, c);
        chk("t6_bias", od[2], 2);
        beat(2, 100, 0, c);
        beat(2, -100, 1, c);
        chk("t6_hold_again", ov[2], 1);
        chk("t6_hold_data", od[2], -25);
        repeat (2) step();

        // Randomized traffic with random result back-pressure.
        for (int d = 0; d < ND; d++) begin
            ordy_rand[d] = 1'b1;
            for (int k = 0; k < 10 * nin_of(d) + 20; k++) begin
                repeat ($urandom_range(0, 2)) step();
                beat(d, int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 255)) - 128, c);
            end
            ordy_rand[d] = 1'b0;
            step();
            drain(d);
        end
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
